// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with
// timeout and bounded retries, then releases the system reset. A loss of
// lock while running re-asserts the system reset and restarts the sequence.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 24,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 240,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_CNT_W          = 8,
  localparam int unsigned RETRY_W = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  lock_fail,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [RETRY_W-1:0]    retry_d;
  logic [LOSS_CNT_W-1:0] loss_d;
  logic                  sync1_q;
  logic                  locked_s;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      locked_s <= sync1_q;
    end
  end

  // Next-state, shared phase counter and retry/loss bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_cnt;
    loss_d  = loss_cnt;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout that falls on the same cycle
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
          if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_PLL_RST;
            retry_d = retry_cnt + RETRY_W'(1);
          end
        end
      end
      S_STABLE: begin
        // A dropout restarts the lock wait without consuming a retry
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = S_PLL_RST;
          retry_d = '0;
          if (loss_cnt != {LOSS_CNT_W{1'b1}}) begin
            loss_d = loss_cnt + LOSS_CNT_W'(1);
          end
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State register and outputs decoded from the next state so they align with it
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      pll_rst   <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      sys_rst   <= (state_d != S_RUN);
      ready     <= (state_d == S_RUN);
      lock_fail <= (state_d == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios plus random lock
// activity, every cycle compared against a countdown-based behavioural model.
module tb_pll_reset_sequencer;

  localparam int unsigned P    = 4;
  localparam int unsigned T    = 20;
  localparam int unsigned L    = 8;
  localparam int unsigned MAXR = 2;
  localparam int unsigned LW   = 2;
  localparam int unsigned RW   = 2;
  localparam int          LOSS_MAX = 3;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic          refclk;
  logic          rst;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          lock_fail;
  logic [RW-1:0] retry_cnt;
  logic [LW-1:0] loss_cnt;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (L),
    .MAX_RETRIES         (MAXR),
    .LOSS_CNT_W          (LW)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_checks;
  int n_errors;
  int cyc;
  int pr_cnt;
  int first_ready;
  int first_fail;

  // Behavioural model: phase, cycles left in the timed phase, counters,
  // and the last two lock samples (decisions use the older one)
  int   m_ph;
  int   m_left;
  int   m_retry;
  int   m_loss;
  logic m_h0;
  logic m_h1;

  task automatic model_step(input logic r, input logic l);
    logic ls;
    if (r) begin
      m_ph = PH_PULSE; m_left = P; m_retry = 0; m_loss = 0;
      m_h0 = 1'b0; m_h1 = 1'b0;
    end else begin
      ls   = m_h1;
      m_h1 = m_h0;
      m_h0 = l;
      case (m_ph)
        PH_PULSE: begin
          m_left--;
          if (m_left == 0) begin m_ph = PH_WAIT; m_left = T; end
        end
        PH_WAIT: begin
          if (ls) begin
            m_ph = PH_STABLE; m_left = L;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retry == MAXR) m_ph = PH_FAIL;
              else begin m_retry++; m_ph = PH_PULSE; m_left = P; end
            end
          end
        end
        PH_STABLE: begin
          if (!ls) begin
            m_ph = PH_WAIT; m_left = T;
          end else begin
            m_left--;
            if (m_left == 0) m_ph = PH_RUN;
          end
        end
        PH_RUN: begin
          if (!ls) begin
            m_ph = PH_PULSE; m_left = P; m_retry = 0;
            if (m_loss < LOSS_MAX) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare();
    check("pll_rst",   int'(pll_rst),   int'(m_ph == PH_PULSE || m_ph == PH_FAIL));
    check("sys_rst",   int'(sys_rst),   int'(m_ph != PH_RUN));
    check("ready",     int'(ready),     int'(m_ph == PH_RUN));
    check("lock_fail", int'(lock_fail), int'(m_ph == PH_FAIL));
    check("retry_cnt", int'(retry_cnt), m_retry);
    check("loss_cnt",  int'(loss_cnt),  m_loss);
  endtask

  task automatic observe();
    if (cyc == 0) begin pr_cnt = 0; first_ready = -1; first_fail = -1; end
    if (pll_rst) pr_cnt++;
    if (ready && first_ready < 0) first_ready = cyc;
    if (lock_fail && first_fail < 0) first_fail = cyc;
  endtask

  task automatic cycle(input logic r, input logic l);
    rst = r;
    pll_locked = l;
    @(posedge refclk);
    model_step(r, l);
    if (r) cyc = 0; else cyc++;
    @(negedge refclk);
    compare();
    observe();
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin cycle(1'b0, 1'b1); n++; end
    check(name, int'(ready), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"},   int'(pll_rst),   1);
    check({tag, "_sys_rst"},   int'(sys_rst),   1);
    check({tag, "_ready"},     int'(ready),     0);
    check({tag, "_lock_fail"}, int'(lock_fail), 0);
    check({tag, "_retry"},     int'(retry_cnt), 0);
    check({tag, "_loss"},      int'(loss_cnt),  0);
  endtask

  task automatic count_pulse(input string name);
    int c;
    c = int'(pll_rst);
    repeat (9) begin cycle(1'b0, pll_locked); c += int'(pll_rst); end
    check(name, c, P);
  endtask

  initial begin
    int lvl;
    int len;
    n_checks = 0; n_errors = 0; cyc = 0;
    pr_cnt = 0; first_ready = -1; first_fail = -1;
    rst = 1'b1; pll_locked = 1'b0;

    // 1: lock from cycle 10, release 2+8 cycles after lock is seen
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check_reset_vals("t1_reset");
    for (int k = 1; k <= 30; k++) cycle(1'b0, 1'(k >= 10));
    check("t1_pulse_width", pr_cnt, 4);
    check("t1_ready_cycle", first_ready, 20);
    check("t1_retry", int'(retry_cnt), 0);
    check("t1_loss", int'(loss_cnt), 0);

    // 2: no lock ever, three pulses then terminal failure
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      cycle(1'b0, 1'b0);
      if (k == 30) check("t2_retry_1", int'(retry_cnt), 1);
      if (k == 60) check("t2_retry_2", int'(retry_cnt), 2);
    end
    check("t2_fail_cycle", first_fail, 72);
    check("t2_lock_fail", int'(lock_fail), 1);
    check("t2_pll_rst", int'(pll_rst), 1);

    // 6b: reset out of the failed state
    cycle(1'b1, 1'b0);
    check_reset_vals("t6_fail_rst");
    count_pulse("t6_fail_pulse");

    // 3: short lock glitch aborts the stable wait without a retry
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) cycle(1'b0, 1'((k >= 10 && k <= 14) || k >= 18));
    check("t3_ready_cycle", first_ready, 28);
    check("t3_retry", int'(retry_cnt), 0);

    // 4/5: five one-cycle lock drops while running, saturating loss count
    for (int i = 0; i < 5; i++) begin
      wait_ready("t5_relock", 60);
      repeat (3) cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("t4_sys_rst", int'(sys_rst), 1);
      check("t4_ready", int'(ready), 0);
      check("t4_retry", int'(retry_cnt), 0);
      check("t5_loss_cnt", int'(loss_cnt), (i < 3) ? i + 1 : 3);
      if (i == 0) count_pulse("t4_pulse_width");
    end

    // 6a: reset while in the stable wait
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) cycle(1'b0, 1'(k >= 10));
    cycle(1'b1, 1'b1);
    check_reset_vals("t6_stable_rst");
    count_pulse("t6_stable_pulse");

    // Random lock activity with occasional resets
    for (int s = 0; s < 60; s++) begin
      if (m_ph == PH_FAIL || $urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(1, 2)) cycle(1'b1, 1'($urandom_range(0, 1)));
      end
      lvl = int'($urandom_range(0, 1));
      if (lvl != 0) len = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 7) == 0) len = int'($urandom_range(60, 90));
      else len = int'($urandom_range(1, 12));
      repeat (len) cycle(1'b0, 1'(lvl));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
